// File: rtl/cntr8_fsm_pkg.sv
// Shared types and constants for the cntr8_fsm up/down counter and its bench.
// State codes are fixed; 3'b110 and 3'b111 are unused.
package cntr8_fsm_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'b000,
    StLoad = 3'b001,
    StInc  = 3'b010,
    StInc2 = 3'b011,
    StDec  = 3'b100,
    StDec2 = 3'b101
  } state_t;

  localparam int unsigned CntWidth = 8;

  // Adder b-operands: +1 and two's-complement -1.
  localparam logic [CntWidth-1:0] IncOperand = 8'h01;
  localparam logic [CntWidth-1:0] DecOperand = 8'hFF;

  function automatic logic is_up(input state_t st);
    return (st == StInc) || (st == StInc2);
  endfunction

  function automatic logic is_down(input state_t st);
    return (st == StDec) || (st == StDec2);
  endfunction

endpackage

// File: rtl/cntr8_fsm_cla8.sv
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups
// joined by a second-level group generate/propagate stage.
module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [7:0] p;
  logic [7:0] g;
  logic [7:0] c;
  logic [1:0] grp_g;
  logic [1:0] grp_p;
  logic       c4;
  logic       cin;

  always_comb begin
    p = a ^ b;
    g = a & b;

    for (int k = 0; k < 2; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
    end

    c4 = grp_g[0] | (grp_p[0] & ci);
    co = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & ci);

    c   = '0;
    cin = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cin = (k == 0) ? ci : c4;
      c[4*k]   = cin;
      c[4*k+1] = g[4*k] | (p[4*k] & cin);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & cin);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cin);
    end

    s = p ^ c;
  end

endmodule

// File: rtl/cntr8_fsm.sv
// Loadable 8-bit up/down counter driven by a small FSM; arithmetic goes through
// a single shared cla8 instance, and all outputs are registered.
module cntr8_fsm
  import cntr8_fsm_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                load,
  input  logic                inc,
  input  logic [CntWidth-1:0] d_in,
  output logic [CntWidth-1:0] o_cnt,
  output logic [2:0]          o_state,
  output logic                o_wrap
);

  state_t              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                wrap_q, wrap_d;

  logic [CntWidth-1:0] add_b;
  logic [CntWidth-1:0] add_sum;
  logic                add_co;

  // Illegal codes never match StInc/StDec, so they fall through to a legal state.
  always_comb begin
    state_d = StIdle;
    if (!en) begin
      state_d = StIdle;
    end else if (load) begin
      state_d = StLoad;
    end else if (inc) begin
      state_d = (state_q == StInc) ? StInc2 : StInc;
    end else begin
      state_d = (state_q == StDec) ? StDec2 : StDec;
    end
  end

  // The adder direction follows the next state so count and state move together.
  assign add_b = is_up(state_d) ? IncOperand : DecOperand;

  cla8 u_cla8 (
    .a  (cnt_q),
    .b  (add_b),
    .ci (1'b0),
    .s  (add_sum),
    .co (add_co)
  );

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    case (state_d)
      StLoad: cnt_d = d_in;
      StInc, StInc2: begin
        cnt_d  = add_sum;
        wrap_d = add_co;
      end
      StDec, StDec2: begin
        cnt_d  = add_sum;
        // Adding FF carries out for every operand except 00.
        wrap_d = ~add_co;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_cnt   = cnt_q;
  assign o_state = state_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_cntr8_fsm.sv
// Directed bench for cntr8_fsm: each task drives a scenario and checks
// count, state and wrap against hand-computed values one cycle per step.
module tb_cntr8_fsm;
  import cntr8_fsm_pkg::*;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic       inc;
  logic [7:0] d_in;
  logic [7:0] o_cnt;
  logic [2:0] o_state;
  logic       o_wrap;

  int n_checks;
  int n_fails;

  cntr8_fsm dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .inc     (inc),
    .d_in    (d_in),
    .o_cnt   (o_cnt),
    .o_state (o_state),
    .o_wrap  (o_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle outputs before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; load = 1'b1; inc = 1'b1; d_in = 8'hAA;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (o_cnt !== 8'h00 || o_state !== 3'(StIdle) || o_wrap !== 1'b0) begin
        $display("FAIL reset[%0d]: cnt=%h state=%b wrap=%b, want 00 000 0",
                 i, o_cnt, o_state, o_wrap);
        n_fails++;
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_count_up();
    logic [7:0] exp_cnt [5];
    logic [2:0] exp_st  [5];
    logic       exp_wr  [5];
    exp_cnt = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_st  = '{3'(StLoad), 3'(StInc), 3'(StInc2), 3'(StInc), 3'(StInc2)};
    exp_wr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    en = 1'b1; load = 1'b1; inc = 1'b0; d_in = 8'hFD;
    for (int i = 0; i < 5; i++) begin
      step();
      load = 1'b0; inc = 1'b1;
      n_checks++;
      if (o_cnt !== exp_cnt[i] || o_state !== exp_st[i] || o_wrap !== exp_wr[i]) begin
        $display("FAIL count_up[%0d]: cnt=%h state=%b wrap=%b, want %h %b %b",
                 i, o_cnt, o_state, o_wrap, exp_cnt[i], exp_st[i], exp_wr[i]);
        n_fails++;
      end
    end
  endtask

  task automatic test_count_down();
    logic [7:0] exp_cnt [5];
    logic [2:0] exp_st  [5];
    logic       exp_wr  [5];
    exp_cnt = '{8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE};
    exp_st  = '{3'(StLoad), 3'(StDec), 3'(StDec2), 3'(StDec), 3'(StDec2)};
    exp_wr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    en = 1'b1; load = 1'b1; inc = 1'b0; d_in = 8'h02;
    for (int i = 0; i < 5; i++) begin
      step();
      load = 1'b0;
      n_checks++;
      if (o_cnt !== exp_cnt[i] || o_state !== exp_st[i] || o_wrap !== exp_wr[i]) begin
        $display("FAIL count_down[%0d]: cnt=%h state=%b wrap=%b, want %h %b %b",
                 i, o_cnt, o_state, o_wrap, exp_cnt[i], exp_st[i], exp_wr[i]);
        n_fails++;
      end
    end
  endtask

  task automatic test_load_no_wrap();
    logic [7:0] vals [2];
    vals = '{8'h00, 8'hFF};
    for (int i = 0; i < 2; i++) begin
      en = 1'b1; load = 1'b1; inc = 1'b1; d_in = vals[i];
      step();
      n_checks++;
      if (o_cnt !== vals[i] || o_state !== 3'(StLoad) || o_wrap !== 1'b0) begin
        $display("FAIL load_no_wrap[%0d]: cnt=%h state=%b wrap=%b, want %h 001 0",
                 i, o_cnt, o_state, o_wrap, vals[i]);
        n_fails++;
      end
    end
    load = 1'b0;
  endtask

  task automatic test_enable_priority();
    en = 1'b1; load = 1'b1; inc = 1'b1; d_in = 8'h0F;
    step();
    load = 1'b0;
    step();
    n_checks++;
    if (o_cnt !== 8'h10 || o_state !== 3'(StInc)) begin
      $display("FAIL en_setup: cnt=%h state=%b, want 10 010", o_cnt, o_state);
      n_fails++;
    end
    // load/inc held high while disabled must be ignored.
    en = 1'b0; load = 1'b1; inc = 1'b1; d_in = 8'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (o_cnt !== 8'h10 || o_state !== 3'(StIdle) || o_wrap !== 1'b0) begin
        $display("FAIL en_hold[%0d]: cnt=%h state=%b wrap=%b, want 10 000 0",
                 i, o_cnt, o_state, o_wrap);
        n_fails++;
      end
    end
    en = 1'b1; load = 1'b1; inc = 1'b1; d_in = 8'h55;
    step();
    n_checks++;
    if (o_cnt !== 8'h55 || o_state !== 3'(StLoad)) begin
      $display("FAIL load_priority: cnt=%h state=%b, want 55 001", o_cnt, o_state);
      n_fails++;
    end
    load = 1'b0;
  endtask

  task automatic test_direction_change();
    inc = 1'b1;
    step();
    step();
    n_checks++;
    if (o_cnt !== 8'h57 || o_state !== 3'(StInc2)) begin
      $display("FAIL dir_setup: cnt=%h state=%b, want 57 011", o_cnt, o_state);
      n_fails++;
    end
    inc = 1'b0;
    step();
    n_checks++;
    if (o_cnt !== 8'h56 || o_state !== 3'(StDec) || o_wrap !== 1'b0) begin
      $display("FAIL dir_change: cnt=%h state=%b wrap=%b, want 56 100 0",
               o_cnt, o_state, o_wrap);
      n_fails++;
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; load = 1'b1; inc = 1'b0; d_in = 8'h81;
    step();
    load = 1'b0;
    step();
    step();
    n_checks++;
    if (o_cnt !== 8'h7F || o_state !== 3'(StDec2)) begin
      $display("FAIL rst_mid_setup: cnt=%h state=%b, want 7F 101", o_cnt, o_state);
      n_fails++;
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (o_cnt !== 8'h00 || o_state !== 3'(StIdle) || o_wrap !== 1'b0) begin
      $display("FAIL rst_mid: cnt=%h state=%b wrap=%b, want 00 000 0",
               o_cnt, o_state, o_wrap);
      n_fails++;
    end
    reset = 1'b0; inc = 1'b1;
    step();
    n_checks++;
    if (o_cnt !== 8'h01 || o_state !== 3'(StInc)) begin
      $display("FAIL rst_release: cnt=%h state=%b, want 01 010", o_cnt, o_state);
      n_fails++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1; en = 1'b0; load = 1'b0; inc = 1'b0; d_in = 8'h00;
    #2;
    test_reset();
    test_count_up();
    test_count_down();
    test_load_no_wrap();
    test_enable_priority();
    test_direction_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
